// File: rtl/tc_product_rescale.sv
// tc_product_rescale
// Takes the signed product from the tracklet calculator's multiplier stage.
// It rounds the product half-up and shifts it right, subtracts the result
// from a signed base term, and saturates the difference to OUT_W bits.
// Any result that had to be clamped is flagged, and a saturating counter
// records how many flagged results were delivered downstream.
//
// The design is a two-stage valid/ready pipeline that collapses bubbles.
// The only combinational path from an input to an output is
// out_ready -> in_ready.

module tc_product_rescale #(
  parameter int PROD_W = 26,
  parameter int BASE_W = 18,
  parameter int SHIFT  = 8,
  parameter int OUT_W  = 18,
  parameter int CNT_W  = 16
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] prod_din,
  input  logic [BASE_W-1:0] base_din,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  dout,
  output logic              dout_oor,
  output logic [CNT_W-1:0]  oor_count
);

  // Width of the rounded, shifted product. The rounding sum is carried
  // in PROD_W+1 bits, so SHIFT bits fewer remain after the shift.
  localparam int R_W = PROD_W + 1 - SHIFT;

  // Width of the difference. It is two bits wider than the wider operand,
  // so base - r can never wrap before saturation is applied.
  localparam int D_W = ((BASE_W > R_W) ? BASE_W : R_W) + 2;

  // Half an LSB of the shifted result. Adding it before the arithmetic
  // shift gives round-half-up (toward +inf).
  localparam logic [PROD_W:0] HALF = (PROD_W + 1)'(1) << (SHIFT - 1);

  // Saturation limits of the signed OUT_W-bit result, expressed at the
  // width of the difference.
  localparam logic signed [D_W-1:0] SAT_MAX = D_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [D_W-1:0] SAT_MIN = D_W'(-(2 ** (OUT_W - 1)));

  // Clamped output codes.
  localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W - 1){1'b1}}};
  localparam logic [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W - 1){1'b0}}};

  // Pipeline occupancy and handshake controls.
  logic s1_valid;
  logic s2_valid;
  logic s2_free;
  logic s1_adv;
  logic in_fire;
  logic out_fire;

  // Stage-1 data: the rounded product and the base term travelling with it.
  logic [R_W-1:0]    s1_r;
  logic [BASE_W-1:0] s1_base;

  // Stage-1 rounding arithmetic.
  logic [PROD_W:0] rnd_sum;
  logic            unused_rnd_lsbs;

  // Stage-2 arithmetic: the full-precision difference and its saturated form.
  logic signed [D_W-1:0] diff;
  logic [OUT_W-1:0]      sat_val;
  logic                  sat_oor;

  // Handshake network. Stage 2 can take new data when it is empty or is
  // draining this cycle. Stage 1 moves forward whenever stage 2 can take
  // its data. The input is accepted whenever stage 1 is empty or moving.
  always_comb begin
    s2_free  = !s2_valid || out_ready;
    s1_adv   = s1_valid && s2_free;
    in_ready = !s1_valid || s2_free;
    in_fire  = in_valid && in_ready;
    out_fire = out_valid && out_ready;
  end

  assign out_valid = s2_valid;

  // Round-half-up the product. It is sign-extended by one bit so that
  // adding the half LSB cannot overflow. The bits below SHIFT are
  // discarded by the shift.
  always_comb begin
    rnd_sum         = {prod_din[PROD_W-1], prod_din} + HALF;
    unused_rnd_lsbs = ^rnd_sum[SHIFT-1:0];
  end

  // Stage-1 register. It loads on every accepted input and empties when
  // its contents move on to stage 2 with nothing new arriving.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      s1_valid <= 1'b0;
      s1_r     <= '0;
      s1_base  <= '0;
    end else begin
      if (in_fire) begin
        s1_valid <= 1'b1;
        s1_r     <= rnd_sum[PROD_W:SHIFT];
        s1_base  <= base_din;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // Subtract the rounded product from the base at full precision, then
  // clamp the difference to the signed OUT_W range and flag any clamping.
  always_comb begin
    diff    = {{(D_W - BASE_W){s1_base[BASE_W-1]}}, s1_base}
            - {{(D_W - R_W){s1_r[R_W-1]}}, s1_r};
    sat_val = diff[OUT_W-1:0];
    sat_oor = 1'b0;
    if (diff > SAT_MAX) begin
      sat_val = OUT_MAX;
      sat_oor = 1'b1;
    end else if (diff < SAT_MIN) begin
      sat_val = OUT_MIN;
      sat_oor = 1'b1;
    end
  end

  // Stage-2 register, which drives the output port. It reloads whenever
  // stage 1 advances, so dout and dout_oor stay stable while the
  // downstream stalls. It empties when its result is taken and stage 1
  // has nothing to replace it with.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      s2_valid <= 1'b0;
      dout     <= '0;
      dout_oor <= 1'b0;
    end else begin
      if (s1_adv) begin
        s2_valid <= 1'b1;
        dout     <= sat_val;
        dout_oor <= sat_oor;
      end else if (out_ready) begin
        s2_valid <= 1'b0;
      end
    end
  end

  // Count delivered saturated results. The counter sticks at all-ones
  // instead of wrapping, so a full count still means "at least this many".
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      oor_count <= '0;
    end else if (out_fire && dout_oor && (oor_count != {CNT_W{1'b1}})) begin
      oor_count <= oor_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_tc_product_rescale.sv
// Testbench for tc_product_rescale.
// A scoreboard queue holds the expected result for every accepted input.
// A negedge monitor pops that queue on every delivered output. Each
// scenario task drives its own stimulus and checks its own
// scenario-specific properties inline. A second instance with a 4-bit
// counter shares the same stimulus and exercises counter saturation.

module tb_tc_product_rescale;

  localparam int PROD_W = 26;
  localparam int BASE_W = 18;
  localparam int SHIFT  = 8;
  localparam int OUT_W  = 18;
  localparam int CNT_W  = 16;

  localparam longint OMAX = (longint'(1) << (OUT_W - 1)) - 1;
  localparam longint OMIN = -(longint'(1) << (OUT_W - 1));

  typedef struct packed {
    logic [OUT_W-1:0] d;
    logic             oor;
  } exp_t;

  logic              ap_clk = 1'b0;
  logic              ap_rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [PROD_W-1:0] prod_din = '0;
  logic [BASE_W-1:0] base_din = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [OUT_W-1:0]  dout;
  logic              dout_oor;
  logic [CNT_W-1:0]  oor_count;

  logic              in_ready4;
  logic              out_valid4;
  logic [OUT_W-1:0]  dout4;
  logic              dout_oor4;
  logic [3:0]        oor_count4;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];
  exp_t mon_exp;

  tc_product_rescale #(
    .PROD_W(PROD_W), .BASE_W(BASE_W), .SHIFT(SHIFT), .OUT_W(OUT_W), .CNT_W(CNT_W)
  ) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .in_valid(in_valid), .in_ready(in_ready),
    .prod_din(prod_din), .base_din(base_din), .out_valid(out_valid),
    .out_ready(out_ready), .dout(dout), .dout_oor(dout_oor), .oor_count(oor_count)
  );

  tc_product_rescale #(
    .PROD_W(PROD_W), .BASE_W(BASE_W), .SHIFT(SHIFT), .OUT_W(OUT_W), .CNT_W(4)
  ) dut4 (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .in_valid(in_valid), .in_ready(in_ready4),
    .prod_din(prod_din), .base_din(base_din), .out_valid(out_valid4),
    .out_ready(out_ready), .dout(dout4), .dout_oor(dout_oor4), .oor_count(oor_count4)
  );

  always #5 ap_clk = ~ap_clk;

  // Reference model: wide integer arithmetic with explicit clamping.
  function automatic exp_t model(input logic [PROD_W-1:0] p, input logic [BASE_W-1:0] b);
    exp_t   e;
    longint pv, bv, r, d;
    pv = longint'($signed(p));
    bv = longint'($signed(b));
    r  = (pv + (longint'(1) << (SHIFT - 1))) >>> SHIFT;
    d  = bv - r;
    e.oor = 1'b1;
    if (d > OMAX)      d = OMAX;
    else if (d < OMIN) d = OMIN;
    else               e.oor = 1'b0;
    e.d = OUT_W'(d);
    return e;
  endfunction

  // Scoreboard monitor: sampled on the falling edge, well away from the
  // rising edge where transfers happen.
  always @(negedge ap_clk) begin
    if (!ap_rst) begin
      if (out_valid && out_ready) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL unexpected_output: got dout=%0d oor=%0b, expected none",
                   $signed(dout), dout_oor);
        end else begin
          mon_exp = sb.pop_front();
          if ({dout, dout_oor} !== {mon_exp.d, mon_exp.oor}) begin
            miscompares++;
            $display("[TB] FAIL scoreboard: got dout=%0d oor=%0b, expected dout=%0d oor=%0b",
                     $signed(dout), dout_oor, $signed(mon_exp.d), mon_exp.oor);
          end
        end
      end
      if (in_valid && in_ready) sb.push_back(model(prod_din, base_din));
    end
  end

  task automatic reset_dut();
    ap_rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (2) begin
      @(posedge ap_clk);
      #1;
    end
    ap_rst = 1'b0;
    sb.delete();
  endtask

  task automatic drain(input string name);
    out_ready = 1'b1;
    in_valid = 1'b0;
    for (int k = 0; k < 20 && sb.size() != 0; k++) begin
      @(posedge ap_clk);
      #1;
    end
    @(posedge ap_clk);
    #1;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL %s_drain: got %0d pending, expected 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    vectors++;
    if ({out_valid, dout, dout_oor, oor_count, in_ready} !== {1'b0, {OUT_W{1'b0}}, 1'b0, {CNT_W{1'b0}}, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL reset_state: got valid=%0b dout=%0h oor=%0b cnt=%0d rdy=%0b, expected 0 0 0 0 1",
               out_valid, dout, dout_oor, oor_count, in_ready);
    end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    in_valid = 1'b1;
    prod_din = 26'd25600;
    base_din = 18'd1000;
    @(posedge ap_clk);
    #1;
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL basic_latency1: got out_valid=%0b, expected 0", out_valid);
    end
    @(posedge ap_clk);
    #1;
    vectors++;
    if ({out_valid, dout, dout_oor} !== {1'b1, 18'd900, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL basic_latency2: got valid=%0b dout=%0d oor=%0b, expected 1 900 0",
               out_valid, $signed(dout), dout_oor);
    end
    drain("basic");
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      prod_din = PROD_W'(i * 1000 - 4000);
      base_din = BASE_W'(i * 7 - 30);
      @(posedge ap_clk);
      #1;
      if (i >= 1) begin
        vectors++;
        if (out_valid !== 1'b1) begin
          miscompares++;
          $display("[TB] FAIL stream_gap_%0d: got out_valid=%0b, expected 1", i, out_valid);
        end
      end
    end
    in_valid = 1'b0;
    @(posedge ap_clk);
    #1;
    vectors++;
    if (out_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL stream_last: got out_valid=%0b, expected 1", out_valid);
    end
    @(posedge ap_clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL stream_end: got out_valid=%0b, expected 0", out_valid);
    end
    drain("stream");
  endtask

  // With base 0 the result is the negated rounded product: -1, 0, 0, 1.
  task automatic test_rounding();
    logic [PROD_W-1:0] prods [4];
    logic [OUT_W-1:0]  want  [4];
    prods[0] = 26'd128;  prods[1] = 26'd127;  prods[2] = -26'sd128; prods[3] = -26'sd129;
    want[0]  = -18'sd1;  want[1]  = 18'd0;    want[2]  = 18'd0;     want[3]  = 18'd1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      prod_din = prods[i];
      base_din = '0;
      @(posedge ap_clk);
      #1;
      in_valid = 1'b0;
      @(posedge ap_clk);
      #1;
      vectors++;
      if ({out_valid, dout, dout_oor} !== {1'b1, want[i], 1'b0}) begin
        miscompares++;
        $display("[TB] FAIL rounding_%0d: got valid=%0b dout=%0d oor=%0b, expected 1 %0d 0",
                 i, out_valid, $signed(dout), dout_oor, $signed(want[i]));
      end
    end
    drain("rounding");
  endtask

  task automatic test_saturation();
    out_ready = 1'b1;
    in_valid = 1'b1;
    prod_din = 26'h2000000;
    base_din = 18'd131071;
    @(posedge ap_clk);
    #1;
    prod_din = 26'd33554176;
    base_din = 18'h20000;
    @(posedge ap_clk);
    #1;
    in_valid = 1'b0;
    vectors++;
    if ({out_valid, dout, dout_oor} !== {1'b1, 18'h1FFFF, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL sat_high: got valid=%0b dout=%0d oor=%0b, expected 1 131071 1",
               out_valid, $signed(dout), dout_oor);
    end
    @(posedge ap_clk);
    #1;
    vectors++;
    if ({out_valid, dout, dout_oor} !== {1'b1, 18'h20000, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL sat_low: got valid=%0b dout=%0d oor=%0b, expected 1 -131072 1",
               out_valid, $signed(dout), dout_oor);
    end
    drain("saturation");
    vectors++;
    if (oor_count !== 16'd2) begin
      miscompares++;
      $display("[TB] FAIL sat_count: got %0d, expected 2", oor_count);
    end
  endtask

  task automatic test_backpressure();
    int               idx = 0;
    logic             acc;
    logic [OUT_W-1:0] held = '0;
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      in_valid = 1'b1;
      prod_din = PROD_W'(idx * 2560 + 300);
      base_din = BASE_W'(idx * 11 - 20);
      #1;
      acc = in_ready;
      vectors++;
      if (in_ready !== (cyc < 2)) begin
        miscompares++;
        $display("[TB] FAIL bp_in_ready_%0d: got %0b, expected %0b", cyc, in_ready, cyc < 2);
      end
      if (cyc == 2) held = dout;
      if (cyc > 2) begin
        vectors++;
        if ({out_valid, dout} !== {1'b1, held}) begin
          miscompares++;
          $display("[TB] FAIL bp_hold_%0d: got valid=%0b dout=%0d, expected 1 %0d",
                   cyc, out_valid, $signed(dout), $signed(held));
        end
      end
      @(posedge ap_clk);
      if (acc) idx++;
      #1;
    end
    vectors++;
    if (idx != 2) begin
      miscompares++;
      $display("[TB] FAIL bp_accepted: got %0d, expected 2", idx);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 10 && idx < 4; k++) begin
      in_valid = 1'b1;
      prod_din = PROD_W'(idx * 2560 + 300);
      base_din = BASE_W'(idx * 11 - 20);
      #1;
      acc = in_ready;
      @(posedge ap_clk);
      if (acc) idx++;
      #1;
    end
    in_valid = 1'b0;
    vectors++;
    if (idx != 4) begin
      miscompares++;
      $display("[TB] FAIL bp_release: got %0d accepted, expected 4", idx);
    end
    drain("backpressure");
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      prod_din = 26'h2000000;
      base_din = 18'd131071;
      @(posedge ap_clk);
      #1;
    end
    in_valid = 1'b0;
    vectors++;
    if ({out_valid, in_ready} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL mid_full: got valid=%0b rdy=%0b, expected 1 0", out_valid, in_ready);
    end
    ap_rst = 1'b1;
    out_ready = 1'b1;
    @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
    sb.delete();
    vectors++;
    if ({out_valid, oor_count, in_ready, dout, dout_oor} !== {1'b0, 16'd0, 1'b1, 18'd0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL mid_reset: got valid=%0b cnt=%0d rdy=%0b dout=%0h oor=%0b, expected 0 0 1 0 0",
               out_valid, oor_count, in_ready, dout, dout_oor);
    end
    for (int k = 0; k < 4; k++) begin
      @(posedge ap_clk);
      #1;
      vectors++;
      if (out_valid !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL mid_stale_%0d: got out_valid=%0b, expected 0", k, out_valid);
      end
    end
  endtask

  task automatic test_counter_sat();
    reset_dut();
    vectors++;
    if ({in_ready4, oor_count4} !== {1'b1, 4'd0}) begin
      miscompares++;
      $display("[TB] FAIL cnt4_reset: got rdy=%0b cnt=%0d, expected 1 0", in_ready4, oor_count4);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 26; i++) begin
      in_valid = (i < 20);
      prod_din = 26'h2000000;
      base_din = 18'd131071;
      @(posedge ap_clk);
      #1;
      if (out_valid4) begin
        vectors++;
        if ({dout4, dout_oor4} !== {18'h1FFFF, 1'b1}) begin
          miscompares++;
          $display("[TB] FAIL cnt4_dout_%0d: got dout=%0d oor=%0b, expected 131071 1",
                   i, $signed(dout4), dout_oor4);
        end
      end
    end
    drain("counter");
    vectors++;
    if ({oor_count4, oor_count} !== {4'd15, 16'd20}) begin
      miscompares++;
      $display("[TB] FAIL cnt_sat: got cnt4=%0d cnt=%0d, expected 15 20", oor_count4, oor_count);
    end
    in_valid = 1'b1;
    repeat (3) begin
      @(posedge ap_clk);
      #1;
    end
    drain("counter_more");
    vectors++;
    if ({oor_count4, oor_count} !== {4'd15, 16'd23}) begin
      miscompares++;
      $display("[TB] FAIL cnt_hold: got cnt4=%0d cnt=%0d, expected 15 23", oor_count4, oor_count);
    end
  endtask

  initial begin
    reset_dut();
    test_reset();
    test_basic();
    test_back_to_back();
    test_rounding();
    test_saturation();
    test_backpressure();
    test_reset_mid();
    test_counter_sat();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
